// File: rtl/clk_div_pkg.sv
// ----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the divided-clock ratio monitor:
//   mon_state_e      - monitor FSM state encoding
//   SYNC_STAGES_DEF  - default synchronizer depth for the divided clock
//   LOCK_COUNT_DEF   - default number of consecutive equal periods for lock
//   TIMEOUT_DEF      - default ref-clock cycles without a rising edge
//   sat_inc8()       - 8-bit increment that sticks at 255
// ----------------------------------------------------------------------------
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // monitor disabled
        ST_ARM  = 2'd1,   // waiting for the first rising edge
        ST_MEAS = 2'd2,   // measuring, not locked
        ST_LOCK = 2'd3    // locked on a stable period
    } mon_state_e;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int LOCK_COUNT_DEF  = 3;
    localparam int TIMEOUT_DEF     = 255;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Multi-flop level synchronizer for a single asynchronous bit.
// Ports:
//   clk_i   in   destination clock (rising edge)
//   rst_ni  in   asynchronous active-low reset, clears every stage
//   d_i     in   asynchronous input bit
//   q_o     out  synchronized level (last stage)
// DEPTH must be 2 or more.
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/clk_ratio_mon.sv
// ----------------------------------------------------------------------------
// clk_ratio_mon
// Measures the period and high-phase length of a divided clock in reference
// clock cycles, locks after LOCK_COUNT consecutive identical periods, flags a
// locked ratio that differs from the expected one, and reports a timeout when
// the divided clock stops toggling.
// Ports:
//   I_ref_clk     in   reference clock, all flops on its rising edge
//   I_rst_n       in   asynchronous active-low reset
//   I_mon_en      in   monitor enable (level)
//   I_div_clk     in   divided clock under test (asynchronous)
//   I_exp_ratio   in   expected ratio; 0 and 1 disable the error check
//   o_ratio       out  last measured period
//   o_high_cnt    out  high-phase length of that period
//   o_meas_valid  out  one-cycle pulse when o_ratio/o_high_cnt update
//   o_locked      out  high while in LOCK
//   o_err         out  locked ratio differs from I_exp_ratio
//   o_timeout     out  no rising edge for TIMEOUT cycles
// ----------------------------------------------------------------------------
module clk_ratio_mon
    import clk_div_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int LOCK_COUNT  = LOCK_COUNT_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic       I_ref_clk,
    input  logic       I_rst_n,
    input  logic       I_mon_en,
    input  logic       I_div_clk,
    input  logic [7:0] I_exp_ratio,
    output logic [7:0] o_ratio,
    output logic [7:0] o_high_cnt,
    output logic       o_meas_valid,
    output logic       o_locked,
    output logic       o_err,
    output logic       o_timeout
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    mon_state_e state_q, state_d;
    logic       sync_lvl;
    logic       prev_lvl_q;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] hcnt_q, hcnt_d;
    logic [1:0] match_q, match_d;
    logic [7:0] ratio_q, ratio_d;
    logic [7:0] high_q, high_d;
    logic       valid_q, valid_d;
    logic       locked_q, locked_d;
    logic       err_q, err_d;
    logic       tout_q, tout_d;

    logic       rise_det;
    logic       timeout_hit;
    logic [7:0] period;
    logic       period_eq;
    logic [1:0] match_inc;

    sync_2ff #(.DEPTH(SYNC_STAGES)) u_sync (
        .clk_i  (I_ref_clk),
        .rst_ni (I_rst_n),
        .d_i    (I_div_clk),
        .q_o    (sync_lvl)
    );

    assign rise_det    = sync_lvl & ~prev_lvl_q;
    // A rising edge in the same cycle wins over the timeout.
    assign timeout_hit = (state_q != ST_IDLE) && (cnt_q == TIMEOUT_C) && !rise_det;
    // cnt was cleared in the previous rise cycle, so the period is cnt + 1.
    assign period      = sat_inc8(cnt_q);
    assign period_eq   = (period == ratio_q);
    assign match_inc   = (match_q == 2'd3) ? match_q : match_q + 2'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = rise_det ? 8'd0 : sat_inc8(cnt_q);
        hcnt_d  = rise_det ? 8'd1 : (sync_lvl ? sat_inc8(hcnt_q) : hcnt_q);
        match_d = match_q;
        ratio_d = ratio_q;
        high_d  = high_q;
        valid_d = 1'b0;
        tout_d  = tout_q;

        if (!I_mon_en) begin
            // Disable wins over everything; measured values are kept.
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
            hcnt_d  = 8'd0;
            match_d = 2'd0;
            tout_d  = 1'b0;
        end else begin
            if (rise_det) begin
                tout_d = 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise_det) begin
                        // First edge only starts the count; nothing captured.
                        state_d = ST_MEAS;
                        match_d = 2'd0;
                    end else if (timeout_hit) begin
                        state_d = ST_ARM;
                        tout_d  = 1'b1;
                        ratio_d = 8'd0;
                        high_d  = 8'd0;
                        match_d = 2'd0;
                    end
                end
                ST_MEAS, ST_LOCK: begin
                    if (rise_det) begin
                        ratio_d = period;
                        high_d  = hcnt_q;
                        valid_d = 1'b1;
                        match_d = period_eq ? match_inc : 2'd0;
                        if (state_q == ST_MEAS && period_eq &&
                            int'(match_inc) == LOCK_COUNT - 1) begin
                            state_d = ST_LOCK;
                        end else if (state_q == ST_LOCK && !period_eq) begin
                            state_d = ST_MEAS;
                        end
                    end else if (timeout_hit) begin
                        state_d = ST_ARM;
                        tout_d  = 1'b1;
                        ratio_d = 8'd0;
                        high_d  = 8'd0;
                        match_d = 2'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Status flags are registered from next-state values so they line up
        // with the o_ratio update that caused them.
        locked_d = (state_d == ST_LOCK);
        err_d    = locked_d && (I_exp_ratio >= 8'd2) && (ratio_d != I_exp_ratio);
    end

    always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q    <= ST_IDLE;
            prev_lvl_q <= 1'b0;
            cnt_q      <= 8'd0;
            hcnt_q     <= 8'd0;
            match_q    <= 2'd0;
            ratio_q    <= 8'd0;
            high_q     <= 8'd0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_lvl_q <= sync_lvl;
            cnt_q      <= cnt_d;
            hcnt_q     <= hcnt_d;
            match_q    <= match_d;
            ratio_q    <= ratio_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            tout_q     <= tout_d;
        end
    end

    assign o_ratio      = ratio_q;
    assign o_high_cnt   = high_q;
    assign o_meas_valid = valid_q;
    assign o_locked     = locked_q;
    assign o_err        = err_q;
    assign o_timeout    = tout_q;

endmodule

// File: tb/tb_clk_ratio_mon.sv
// ----------------------------------------------------------------------------
// tb_clk_ratio_mon
// Directed bench for clk_ratio_mon. Every valid pulse is checked against an
// expected queue of {ratio, high_cnt, locked, err}; level checks are made at
// fixed points in the sequence. Inputs change on the falling edge of the
// reference clock and outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_clk_ratio_mon;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       mon_en    = 1'b0;
    logic       div_clk   = 1'b0;
    logic [7:0] exp_ratio = 8'd0;

    logic [7:0] o_ratio;
    logic [7:0] o_high_cnt;
    logic       o_meas_valid;
    logic       o_locked;
    logic       o_err;
    logic       o_timeout;

    int n_cmp   = 0;
    int n_fail  = 0;
    int n_valid = 0;

    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    clk_ratio_mon dut (
        .I_ref_clk    (clk),
        .I_rst_n      (rst_n),
        .I_mon_en     (mon_en),
        .I_div_clk    (div_clk),
        .I_exp_ratio  (exp_ratio),
        .o_ratio      (o_ratio),
        .o_high_cnt   (o_high_cnt),
        .o_meas_valid (o_meas_valid),
        .o_locked     (o_locked),
        .o_err        (o_err),
        .o_timeout    (o_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] ratio, input logic [7:0] high,
                            input logic locked, input logic err);
        exp_q.push_back({ratio, high, locked, err});
    endtask

    // n periods of the divided clock, each 'high' cycles high then 'low' low.
    task automatic div_periods(input int high, input int low, input int n);
        for (int i = 0; i < n; i++) begin
            div_clk = 1'b1;
            repeat (high) @(negedge clk);
            div_clk = 1'b0;
            repeat (low) @(negedge clk);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {12'd0, o_ratio, o_high_cnt, o_meas_valid, o_locked, o_err, o_timeout};
    endfunction

    // Scoreboard: every valid pulse must match the head of exp_q.
    always @(negedge clk) begin
        if (o_meas_valid === 1'b1) begin
            n_valid++;
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_valid: observed ratio=%0d high=%0d expected no pulse",
                       o_ratio, o_high_cnt);
            end
            if (exp_q.size() > 0) begin
                logic [17:0] e;
                e = exp_q.pop_front();
                check("valid_pulse", {14'd0, o_ratio, o_high_cnt, o_locked, o_err}, {14'd0, e});
            end
        end
    end

    initial begin
        int valid_before;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", all_outs(), 32'd0);

        // Stable divide-by-4, expected 4: lock on third valid pulse
        rst_n     = 1'b1;
        mon_en    = 1'b1;
        exp_ratio = 8'd4;
        repeat (3) @(negedge clk);
        push_exp(8'd4, 8'd2, 1'b0, 1'b0);
        push_exp(8'd4, 8'd2, 1'b0, 1'b0);
        push_exp(8'd4, 8'd2, 1'b1, 1'b0);
        push_exp(8'd4, 8'd2, 1'b1, 1'b0);
        push_exp(8'd4, 8'd2, 1'b1, 1'b0);
        div_periods(2, 2, 6);
        check("div4_locked", {31'd0, o_locked}, 32'd1);
        check("div4_err", {31'd0, o_err}, 32'd0);

        // Switch to divide-by-8 while locked: unlock, then re-lock at 8
        push_exp(8'd4, 8'd2, 1'b1, 1'b0);
        push_exp(8'd8, 8'd4, 1'b0, 1'b0);
        push_exp(8'd8, 8'd4, 1'b0, 1'b0);
        push_exp(8'd8, 8'd4, 1'b1, 1'b1);
        div_periods(4, 4, 4);
        check("div8_relock", {31'd0, o_locked}, 32'd1);
        check("div8_err", {31'd0, o_err}, 32'd1);
        check("div8_ratio", {24'd0, o_ratio}, 32'd8);

        // Drop enable while locked: flags clear, measurement held, no pulses
        mon_en = 1'b0;
        @(negedge clk);
        check("disable_locked", {31'd0, o_locked}, 32'd0);
        check("disable_err", {31'd0, o_err}, 32'd0);
        check("disable_ratio", {24'd0, o_ratio}, 32'd8);
        check("disable_high", {24'd0, o_high_cnt}, 32'd4);
        valid_before = n_valid;
        div_periods(2, 2, 3);
        check("disable_no_valid", n_valid, valid_before);
        check("disable_ratio_hold", {24'd0, o_ratio}, 32'd8);

        // Divide-by-5 (2 high, 3 low) against expected 6: lock with error
        exp_ratio = 8'd6;
        mon_en    = 1'b1;
        repeat (2) @(negedge clk);
        push_exp(8'd5, 8'd2, 1'b0, 1'b0);
        push_exp(8'd5, 8'd2, 1'b0, 1'b0);
        push_exp(8'd5, 8'd2, 1'b1, 1'b1);
        push_exp(8'd5, 8'd2, 1'b1, 1'b1);
        div_periods(2, 3, 5);
        check("div5_locked", {31'd0, o_locked}, 32'd1);
        check("div5_err", {31'd0, o_err}, 32'd1);

        // Hold the divided clock low: timeout ~254 cycles after this point
        repeat (240) @(negedge clk);
        check("pre_timeout", {31'd0, o_timeout}, 32'd0);
        check("pre_timeout_locked", {31'd0, o_locked}, 32'd1);
        repeat (60) @(negedge clk);
        check("timeout_outputs", all_outs(), 32'd1);

        // First divide-by-4 edge clears the timeout without a capture
        exp_ratio = 8'd4;
        div_periods(2, 2, 1);
        check("timeout_cleared", {31'd0, o_timeout}, 32'd0);
        check("timeout_no_capture", {24'd0, o_ratio}, 32'd0);
        push_exp(8'd4, 8'd2, 1'b0, 1'b0);
        push_exp(8'd4, 8'd2, 1'b0, 1'b0);
        push_exp(8'd4, 8'd2, 1'b1, 1'b0);
        push_exp(8'd4, 8'd2, 1'b1, 1'b0);
        div_periods(2, 2, 4);
        check("relock_after_timeout", {31'd0, o_locked}, 32'd1);

        // Reset mid-period while locked: outputs clear asynchronously
        div_clk = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", all_outs(), 32'd0);
        div_clk = 1'b0;
        repeat (3) @(negedge clk);
        check("held_reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        // First rise after reset only arms; captures begin at the second.
        push_exp(8'd4, 8'd2, 1'b0, 1'b0);
        push_exp(8'd4, 8'd2, 1'b0, 1'b0);
        div_periods(2, 2, 3);
        check("post_reset_unlocked", {31'd0, o_locked}, 32'd0);
        check("post_reset_ratio", {24'd0, o_ratio}, 32'd4);

        repeat (4) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
